aes_mmio_frontend: RTL and testbench

//  Memory-mapped front end for the iterative aes core on the shrv32 data bus.
//  - CPU writes key and plaintext as 32-bit words, then sets START.
//  - Block holds both operands stable, pulses the core's we, waits for busy to fall,

---
 rtl/aes_mmio_pkg.sv | 45 ++++
 rtl/aes_mmio_frontend.sv | 183 ++++++++++++++++++
 tb/tb_aes_mmio_frontend.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_mmio_pkg.sv
// Shared definitions for the AES MMIO front end.
// Contents: word-address regions, CTRL bit positions, FSM state type and
// helpers that convert between four 32-bit words and a 128-bit operand.
// Word n always occupies bits [32n+31:32n] of the 128-bit vector.
package aes_mmio_pkg;

    typedef logic [3:0][31:0] words_t;

    // bus_addr[3:2] selects the register group, bus_addr[1:0] the word in it
    localparam logic [1:0] REGION_KEY  = 2'd0;   // words 0-3
    localparam logic [1:0] REGION_PT   = 2'd1;   // words 4-7
    localparam logic [1:0] REGION_CT   = 2'd2;   // words 8-11
    localparam logic [1:0] REGION_CTRL = 2'd3;   // word 12 = CTRL, 13-15 reserved
    localparam logic [1:0] CTRL_WORD   = 2'd0;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_BUSY   = 1;
    localparam int unsigned CTRL_DONE   = 2;
    localparam int unsigned CTRL_IRQ_EN = 3;
    localparam int unsigned CTRL_ERR    = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_CORE,
        RUN,
        CAPTURE
    } fsm_t;

    function automatic logic [127:0] pack_words(input words_t w);
        logic [127:0] v;
        for (int unsigned n = 0; n < 4; n++) begin
            v[32*n +: 32] = w[n];
        end
        return v;
    endfunction

    function automatic words_t unpack_words(input logic [127:0] v);
        words_t w;
        for (int unsigned n = 0; n < 4; n++) begin
            w[n] = v[32*n +: 32];
        end
        return w;
    endfunction

endpackage

// File: rtl/aes_mmio_frontend.sv
// Memory-mapped front end for the iterative AES core.
// The CPU loads KEY/PT words, sets CTRL.START; the block launches the core
// with a single aes_we pulse once the core is idle, waits for busy to fall,
// captures the cipher into the read-only CT words and raises DONE/irq.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   bus_req/we/addr/wdata   word-addressed bus access, one access per sampled req
//   bus_rdata, bus_ready    registered response, rdata is 0 unless ready
//   irq                     level (done & irq_en) or one-cycle pulse (IRQ_LEVEL=0)
//   aes_plaintext/secret    operands to the core, frozen while busy
//   aes_we                  one-cycle launch strobe to the core
//   aes_cipher, aes_busy    results/status from the core
module aes_mmio_frontend
    import aes_mmio_pkg::*;
#(
    parameter int unsigned AW        = 4,
    parameter bit          IRQ_LEVEL = 1'b1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          bus_req,
    input  logic          bus_we,
    input  logic [AW-1:0] bus_addr,
    input  logic [31:0]   bus_wdata,
    output logic [31:0]   bus_rdata,
    output logic          bus_ready,
    output logic          irq,
    output logic [127:0]  aes_plaintext,
    output logic [127:0]  aes_secret,
    output logic          aes_we,
    input  logic [127:0]  aes_cipher,
    input  logic          aes_busy
);

    words_t      key_q, key_d;
    words_t      pt_q, pt_d;
    words_t      ct_q, ct_d;
    logic        done_q, done_d;
    logic        irq_en_q, irq_en_d;
    logic        err_q, err_d;
    logic        irq_pulse_q, irq_pulse_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    fsm_t        state_q, state_d;

    logic        busy;
    logic        in_range;
    logic        start;
    logic [1:0]  region;
    logic [1:0]  widx;
    logic [31:0] rd;

    // Read-only / reserved CTRL bits carry no state.
    logic        unused_wdata;
    assign unused_wdata = ^{bus_wdata[31:5], bus_wdata[CTRL_BUSY]};

    assign region   = bus_addr[3:2];
    assign widx     = bus_addr[1:0];
    assign in_range = (bus_addr >> 4) == '0;
    assign busy     = (state_q != IDLE);

    always_comb begin
        key_d       = key_q;
        pt_d        = pt_q;
        ct_d        = ct_q;
        done_d      = done_q;
        irq_en_d    = irq_en_q;
        err_d       = err_q;
        irq_pulse_d = 1'b0;
        state_d     = state_q;
        aes_we      = 1'b0;
        start       = 1'b0;
        rd          = '0;

        // Read mux: value before any write on the same edge
        if (in_range) begin
            unique case (region)
                REGION_KEY:  rd = key_q[widx];
                REGION_PT:   rd = pt_q[widx];
                REGION_CT:   rd = ct_q[widx];
                REGION_CTRL: begin
                    if (widx == CTRL_WORD) begin
                        rd[CTRL_BUSY]   = busy;
                        rd[CTRL_DONE]   = done_q;
                        rd[CTRL_IRQ_EN] = irq_en_q;
                        rd[CTRL_ERR]    = err_q;
                    end
                end
                default: rd = '0;
            endcase
        end
        rdata_d = bus_req ? rd : '0;
        ready_d = bus_req;

        // Register writes
        if (bus_req && bus_we && in_range) begin
            unique case (region)
                REGION_KEY: begin
                    if (busy) err_d = 1'b1;
                    else      key_d[widx] = bus_wdata;
                end
                REGION_PT: begin
                    if (busy) err_d = 1'b1;
                    else      pt_d[widx] = bus_wdata;
                end
                REGION_CTRL: begin
                    if (widx == CTRL_WORD) begin
                        irq_en_d = bus_wdata[CTRL_IRQ_EN];
                        if (bus_wdata[CTRL_DONE]) done_d = 1'b0;
                        if (bus_wdata[CTRL_ERR])  err_d  = 1'b0;
                        // a rejected START must win over an ERR clear in the same write
                        if (bus_wdata[CTRL_START]) begin
                            if (busy) err_d = 1'b1;
                            else      start = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_CORE;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            // The core has no reset, so it may still be finishing a job
            // launched before our reset; never launch over it.
            WAIT_CORE: begin
                if (!aes_busy) begin
                    aes_we  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!aes_busy) state_d = CAPTURE;
            end
            CAPTURE: begin
                ct_d        = unpack_words(aes_cipher);
                done_d      = 1'b1;
                irq_pulse_d = irq_en_d;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            key_q       <= '0;
            pt_q        <= '0;
            ct_q        <= '0;
            done_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            err_q       <= 1'b0;
            irq_pulse_q <= 1'b0;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            state_q     <= IDLE;
        end else begin
            key_q       <= key_d;
            pt_q        <= pt_d;
            ct_q        <= ct_d;
            done_q      <= done_d;
            irq_en_q    <= irq_en_d;
            err_q       <= err_d;
            irq_pulse_q <= irq_pulse_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            state_q     <= state_d;
        end
    end

    assign bus_rdata     = rdata_q;
    assign bus_ready     = ready_q;
    assign irq           = IRQ_LEVEL ? (done_q & irq_en_q) : irq_pulse_q;
    assign aes_secret    = pack_words(key_q);
    assign aes_plaintext = pack_words(pt_q);

endmodule

// File: tb/tb_aes_mmio_frontend.sv
// Self-checking bench for aes_mmio_frontend.
// A behavioural core stand-in (10 busy cycles per job, no reset) drives
// aes_cipher/aes_busy. Read expectations go into a scoreboard queue when
// the access is issued and are compared when bus_ready returns.
// A second instance with IRQ_LEVEL=0 shares all inputs to check pulse irq.
module tb_aes_mmio_frontend;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] MIX    = 128'h0123456789abcdeffedcba9876543210;

    logic         clock = 1'b0;
    logic         reset;
    logic         bus_req;
    logic         bus_we;
    logic [3:0]   bus_addr;
    logic [31:0]  bus_wdata;
    logic [31:0]  bus_rdata;
    logic         bus_ready;
    logic         irq;
    logic [127:0] aes_plaintext;
    logic [127:0] aes_secret;
    logic         aes_we;
    logic [127:0] aes_cipher;
    logic         aes_busy;

    logic [31:0]  d2_unused_rdata;
    logic         d2_unused_ready;
    logic [127:0] d2_unused_pt;
    logic [127:0] d2_unused_key;
    logic         irq2;
    logic         we2;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    aes_mmio_frontend #(.AW(4), .IRQ_LEVEL(1'b1)) dut (
        .clock(clock), .reset(reset),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready), .irq(irq),
        .aes_plaintext(aes_plaintext), .aes_secret(aes_secret), .aes_we(aes_we),
        .aes_cipher(aes_cipher), .aes_busy(aes_busy)
    );

    aes_mmio_frontend #(.AW(4), .IRQ_LEVEL(1'b0)) dut_pulse (
        .clock(clock), .reset(reset),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(d2_unused_rdata), .bus_ready(d2_unused_ready), .irq(irq2),
        .aes_plaintext(d2_unused_pt), .aes_secret(d2_unused_key), .aes_we(we2),
        .aes_cipher(aes_cipher), .aes_busy(aes_busy)
    );

    // ---------------- core stand-in ----------------
    logic         core_busy = 1'b0;
    logic [3:0]   core_cnt  = '0;
    logic [127:0] core_ct   = '0;
    logic         collide   = 1'b0;
    int           we_count  = 0;
    int           we2_count = 0;
    int           irq2_cnt  = 0;

    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
        if (k == C1_KEY && p == C1_PT) return C1_CT;
        return k ^ {p[63:0], p[127:64]} ^ MIX;
    endfunction

    always @(posedge clock) begin
        if (aes_we) begin
            if (core_busy) collide <= 1'b1;
            core_busy <= 1'b1;
            core_cnt  <= 4'd9;
            core_ct   <= core_fn(aes_secret, aes_plaintext);
            we_count  <= we_count + 1;
        end else if (core_busy) begin
            if (core_cnt == 0) core_busy <= 1'b0;
            else               core_cnt  <= core_cnt - 1;
        end
        if (we2) we2_count <= we2_count + 1;
    end

    always @(negedge clock) if (irq2) irq2_cnt <= irq2_cnt + 1;

    assign aes_busy   = core_busy;
    // garbage while running so an early capture is visible
    assign aes_cipher = core_busy ? {4{32'hdeadbeef}} : core_ct;

    // ---------------- scoreboard / helpers ----------------
    typedef struct {
        string       tag;
        logic [31:0] exp;
    } rd_t;
    rd_t sb[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output bit got);
        @(negedge clock);
        bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
        @(negedge clock);
        bus_req = 1'b0; bus_we = 1'b0;
        got = bus_ready;
        for (int k = 0; k < 3 && !got; k++) begin
            @(negedge clock);
            got = bus_ready;
        end
        rd = bus_rdata;
        if (!got) check("bus_ready_timeout", 1'b0, 1'b1);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        bit got;
        bus(1'b1, addr, data, rd, got);
    endtask

    task automatic rdchk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        bit got;
        rd_t e;
        sb.push_back('{tag, exp});
        bus(1'b0, addr, 32'h0, rd, got);
        e = sb.pop_front();
        if (got) check(e.tag, rd, e.exp);
    endtask

    task automatic wait_idle();
        logic [31:0] rd;
        bit got;
        bit idle = 1'b0;
        for (int k = 0; k < 40 && !idle; k++) begin
            bus(1'b0, 4'd12, 32'h0, rd, got);
            idle = got && !rd[1];
        end
        if (!idle) check("idle_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_we(output bit seen, output logic busy_at);
        for (int k = 0; k < 40 && !aes_we; k++) @(negedge clock);
        seen    = aes_we;
        busy_at = aes_busy;
        if (!seen) check("we_timeout", 1'b0, 1'b1);
    endtask

    // cycles from the aes_we cycle until irq is observed
    task automatic measure(output int lat);
        bit   seen;
        logic busy_at;
        lat = -1;
        wait_we(seen, busy_at);
        if (seen) begin
            for (int n = 1; n <= 40; n++) begin
                @(negedge clock);
                if (irq) begin
                    lat = n;
                    break;
                end
            end
        end
    endtask

    task automatic load_c1();
        logic [127:0] k = C1_KEY;
        logic [127:0] p = C1_PT;
        for (int n = 0; n < 4; n++) begin
            wr(4'(n), k[32*n +: 32]);
            wr(4'(4 + n), p[32*n +: 32]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] ct  = C1_CT;
        logic [127:0] pt  = C1_PT;
        logic [127:0] key = C1_KEY;
        logic [127:0] mix = MIX;
        int   lat;
        int   w0, i0;
        bit   seen;
        logic busy_at;

        reset = 1'b1; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // reset state
        check("rst_ready", bus_ready, 1'b0);
        check("rst_rdata", bus_rdata, 32'h0);
        check("rst_irq", irq, 1'b0);
        check("rst_irq2", irq2, 1'b0);
        check("rst_we", aes_we, 1'b0);
        rdchk("rst_ctrl", 4'd12, 32'h0);
        rdchk("rst_key0", 4'd0, 32'h0);
        rdchk("rst_ct3", 4'd11, 32'h0);

        // FIPS-197 C.1 with IRQ enabled
        load_c1();
        rdchk("key3_rb", 4'd3, key[127:96]);
        rdchk("pt0_rb", 4'd4, pt[31:0]);
        wr(4'd12, 32'h9);
        check("launch_key", aes_secret, C1_KEY);
        check("launch_pt", aes_plaintext, C1_PT);
        measure(lat);
        check("c1_latency", lat, 13);
        for (int n = 0; n < 4; n++) rdchk($sformatf("c1_ct%0d", n), 4'(8 + n), ct[32*n +: 32]);
        rdchk("c1_ctrl", 4'd12, 32'hC);
        check("irq_level_held", irq, 1'b1);
        check("irq2_pulse_once", irq2_cnt, 1);

        // DONE W1C drops irq
        wr(4'd12, 32'h4);
        check("irq_cleared", irq, 1'b0);
        rdchk("ctrl_cleared", 4'd12, 32'h0);

        // busy protection
        w0 = we_count;
        wr(4'd12, 32'h1);
        repeat (3) @(negedge clock);
        wr(4'd4, 32'hffffffff);
        rdchk("ctrl_err_pt", 4'd12, 32'h12);
        wr(4'd12, 32'h10);
        wr(4'd12, 32'h1);
        rdchk("ctrl_err_start", 4'd12, 32'h12);
        wait_idle();
        rdchk("pt0_kept", 4'd4, pt[31:0]);
        for (int n = 0; n < 4; n++) rdchk($sformatf("busy_ct%0d", n), 4'(8 + n), ct[32*n +: 32]);
        rdchk("ctrl_done_err", 4'd12, 32'h14);
        check("busy_we_pulses", we_count - w0, 1);

        // reset in the middle of a run
        wr(4'd12, 32'h1);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        wr(4'd12, 32'h1);
        check("we_held_core_busy", aes_we, 1'b0);
        wait_we(seen, busy_at);
        check("we_after_busy_low", busy_at, 1'b0);
        wait_idle();
        rdchk("rst_run_ct0", 4'd8, mix[31:0]);
        rdchk("rst_run_ct3", 4'd11, mix[127:96]);
        load_c1();
        wr(4'd12, 32'h1);
        wait_idle();
        for (int n = 0; n < 4; n++) rdchk($sformatf("rerun_ct%0d", n), 4'(8 + n), ct[32*n +: 32]);

        // back-to-back START + DONE W1C
        wr(4'd12, 32'h8);
        w0 = we_count;
        i0 = irq2_cnt;
        for (int r = 0; r < 3; r++) begin
            wr(4'd12, 32'hD);
            measure(lat);
            check($sformatf("b2b_latency%0d", r), lat, 13);
        end
        @(negedge clock);
        check("b2b_we_pulses", we_count - w0, 3);
        check("b2b_irq2_pulses", irq2_cnt - i0, 3);

        // reserved words, START readback, ready width
        wr(4'd13, 32'hffffffff);
        rdchk("addr13", 4'd13, 32'h0);
        @(negedge clock);
        check("ready_one_cycle", bus_ready, 1'b0);
        rdchk("addr14", 4'd14, 32'h0);
        rdchk("addr15", 4'd15, 32'h0);
        rdchk("ctrl_start_reads0", 4'd12, 32'hC);

        check("core_overlap", collide, 1'b0);
        check("pulse_inst_we", we2_count, we_count);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
